// File: rtl/mtm_alu_tx_scheduler.sv
// Transmit scheduler for the MTM ALU: queues result words in a small FIFO, holds one
// pending error report, and hands frames to the serializer with an ack-based handshake.
module mtm_alu_tx_scheduler #(
  parameter int DEPTH       = 4,
  parameter int ACK_TIMEOUT = 1024
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        res_valid,
  output logic        res_ready,
  input  logic [31:0] res_data,
  input  logic [2:0]  res_crc,
  input  logic [3:0]  res_flags,
  input  logic        err_valid,
  output logic        err_ready,
  input  logic [2:0]  err_bits,
  output logic        ser_req,
  output logic [31:0] ser_data,
  output logic [2:0]  ser_crc,
  output logic [3:0]  ser_flags,
  output logic        ser_data_err,
  output logic        ser_crc_err,
  output logic        ser_op_err,
  input  logic        ser_ack,
  output logic [4:0]  fifo_level,
  output logic        tx_timeout
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(ACK_TIMEOUT + 1);
  localparam logic [4:0]    DEPTH_L  = 5'(DEPTH);
  localparam logic [CW-1:0] CNT_LAST = CW'(ACK_TIMEOUT - 1);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT_START, WAIT_DONE} state_t;

  state_t        state_q, state_d;
  logic [38:0]   mem_q [DEPTH];
  logic [AW-1:0] wrPtr_q, wrPtr_d, rdPtr_q, rdPtr_d;
  logic [4:0]    level_q, level_d;
  logic          errPending_q, errPending_d;
  logic [2:0]    errBits_q, errBits_d;
  logic          isErr_q, isErr_d;
  logic          serReq_q, serReq_d;
  logic [31:0]   serData_q, serData_d;
  logic [2:0]    serCrc_q, serCrc_d;
  logic [3:0]    serFlags_q, serFlags_d;
  logic [2:0]    serErr_q, serErr_d;
  logic          timeout_q, timeout_d;
  logic [CW-1:0] cnt_q, cnt_d;

  logic push, pop, errCapture;

  assign res_ready  = (level_q < DEPTH_L);
  assign err_ready  = !errPending_q;
  assign push       = res_valid & res_ready;
  assign pop        = (state_q == ISSUE) & !isErr_q;
  assign errCapture = err_valid & err_ready & (err_bits != 3'b000);

  always_comb begin
    state_d      = state_q;
    wrPtr_d      = wrPtr_q;
    rdPtr_d      = rdPtr_q;
    level_d      = level_q;
    errPending_d = errPending_q;
    errBits_d    = errBits_q;
    isErr_d      = isErr_q;
    serReq_d     = serReq_q;
    serData_d    = serData_q;
    serCrc_d     = serCrc_q;
    serFlags_d   = serFlags_q;
    serErr_d     = serErr_q;
    timeout_d    = timeout_q;
    cnt_d        = cnt_q;

    if (push) wrPtr_d = wrPtr_q + 1'b1;
    if (pop)  rdPtr_d = rdPtr_q + 1'b1;
    case ({push, pop})
      2'b10:   level_d = level_q + 5'd1;
      2'b01:   level_d = level_q - 5'd1;
      default: level_d = level_q;
    endcase

    if ((state_q == ISSUE) && isErr_q) errPending_d = 1'b0;
    if (errCapture) begin
      errPending_d = 1'b1;
      errBits_d    = err_bits;
    end

    case (state_q)
      IDLE: begin
        // Error reports always win over queued results.
        if ((errPending_q || (level_q != 5'd0)) && ser_ack) begin
          state_d  = ISSUE;
          serReq_d = 1'b1;
          if (errPending_q) begin
            isErr_d    = 1'b1;
            serData_d  = 32'h0;
            serCrc_d   = 3'b000;
            serFlags_d = 4'b0000;
            serErr_d   = errBits_q;
          end else begin
            isErr_d                            = 1'b0;
            {serData_d, serCrc_d, serFlags_d}  = mem_q[rdPtr_q];
            serErr_d                           = 3'b000;
          end
        end
      end
      ISSUE: begin
        state_d = WAIT_START;
        cnt_d   = '0;
      end
      WAIT_START: begin
        if (!ser_ack) begin
          state_d  = WAIT_DONE;
          serReq_d = 1'b0;
        end else if (cnt_q == CNT_LAST) begin
          state_d   = IDLE;
          serReq_d  = 1'b0;
          timeout_d = 1'b1;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      WAIT_DONE: begin
        if (ser_ack) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      wrPtr_q      <= '0;
      rdPtr_q      <= '0;
      level_q      <= 5'd0;
      errPending_q <= 1'b0;
      errBits_q    <= 3'b000;
      isErr_q      <= 1'b0;
      serReq_q     <= 1'b0;
      serData_q    <= 32'h0;
      serCrc_q     <= 3'b000;
      serFlags_q   <= 4'b0000;
      serErr_q     <= 3'b000;
      timeout_q    <= 1'b0;
      cnt_q        <= '0;
    end else begin
      state_q      <= state_d;
      wrPtr_q      <= wrPtr_d;
      rdPtr_q      <= rdPtr_d;
      level_q      <= level_d;
      errPending_q <= errPending_d;
      errBits_q    <= errBits_d;
      isErr_q      <= isErr_d;
      serReq_q     <= serReq_d;
      serData_q    <= serData_d;
      serCrc_q     <= serCrc_d;
      serFlags_q   <= serFlags_d;
      serErr_q     <= serErr_d;
      timeout_q    <= timeout_d;
      cnt_q        <= cnt_d;
    end
  end

  // Storage needs no reset: only entries between the pointers are ever read.
  always_ff @(posedge clk) begin
    if (push) mem_q[wrPtr_q] <= {res_data, res_crc, res_flags};
  end

  assign ser_req      = serReq_q;
  assign ser_data     = serData_q;
  assign ser_crc      = serCrc_q;
  assign ser_flags    = serFlags_q;
  assign ser_data_err = serErr_q[2];
  assign ser_crc_err  = serErr_q[1];
  assign ser_op_err   = serErr_q[0];
  assign fifo_level   = level_q;
  assign tx_timeout   = timeout_q;

endmodule

// File: tb/tb_mtm_alu_tx_scheduler.sv
// Scoreboard bench for mtm_alu_tx_scheduler: directed frames are queued as expectations
// and a monitor compares each frame the DUT raises ser_req for.
module tb_mtm_alu_tx_scheduler;

  localparam int ACK_AUTO = 0;
  localparam int ACK_HIGH = 1;
  localparam int ACK_LOW  = 2;

  typedef logic [41:0] frame_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        res_valid;
  logic        res_ready;
  logic [31:0] res_data;
  logic [2:0]  res_crc;
  logic [3:0]  res_flags;
  logic        err_valid;
  logic        err_ready;
  logic [2:0]  err_bits;
  logic        ser_req;
  logic [31:0] ser_data;
  logic [2:0]  ser_crc;
  logic [3:0]  ser_flags;
  logic        ser_data_err;
  logic        ser_crc_err;
  logic        ser_op_err;
  logic        ser_ack;
  logic [4:0]  fifo_level;
  logic        tx_timeout;

  frame_t expQ[$];
  int     checks = 0;
  int     errors = 0;
  int     ackMode = ACK_AUTO;
  int     busyLen = 20;
  int     busyCnt;

  mtm_alu_tx_scheduler #(.DEPTH(4), .ACK_TIMEOUT(1024)) dut (
    .clk(clk), .rst(rst),
    .res_valid(res_valid), .res_ready(res_ready), .res_data(res_data),
    .res_crc(res_crc), .res_flags(res_flags),
    .err_valid(err_valid), .err_ready(err_ready), .err_bits(err_bits),
    .ser_req(ser_req), .ser_data(ser_data), .ser_crc(ser_crc), .ser_flags(ser_flags),
    .ser_data_err(ser_data_err), .ser_crc_err(ser_crc_err), .ser_op_err(ser_op_err),
    .ser_ack(ser_ack), .fifo_level(fifo_level), .tx_timeout(tx_timeout)
  );

  always #5 clk = ~clk;

  function automatic frame_t resFrame(input logic [31:0] d, input logic [2:0] c, input logic [3:0] f);
    return {d, c, f, 3'b000};
  endfunction

  function automatic frame_t errFrame(input logic [2:0] b);
    return {32'h0, 3'b000, 4'b0000, b};
  endfunction

  task automatic checkOutput(input string name, input logic [41:0] actual, input logic [41:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s actual=%0h expected=%0h", name, actual, expected);
    end
  endtask

  task automatic waitExpired(input string name);
    checks++;
    errors++;
    $display("[TB] FAIL %s wait bound expired actual=expired expected=event", name);
  endtask

  task automatic applyStimulus(input logic [31:0] d, input logic [2:0] c, input logic [3:0] f,
                               input bit expectFrame);
    int n = 0;
    res_valid = 1'b1;
    res_data  = d;
    res_crc   = c;
    res_flags = f;
    while (!res_ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (n >= 200) waitExpired("resAccept");
    if (expectFrame) expQ.push_back(resFrame(d, c, f));
    @(negedge clk);
    res_valid = 1'b0;
  endtask

  task automatic applyErrorStimulus(input logic [2:0] b, input bit expectFrame);
    int n = 0;
    err_valid = 1'b1;
    err_bits  = b;
    while (!err_ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (n >= 200) waitExpired("errAccept");
    if (expectFrame) expQ.push_back(errFrame(b));
    @(negedge clk);
    err_valid = 1'b0;
    err_bits  = 3'b000;
  endtask

  task automatic waitDrain(input int limit);
    int n = 0;
    while (!(expQ.size() == 0 && !ser_req && ser_ack && fifo_level == 5'd0) && n < limit) begin
      @(negedge clk);
      n++;
    end
    if (n >= limit) waitExpired("drain");
    repeat (2) @(negedge clk);
  endtask

  // Serializer model, acting just after the rising edge so it never races the DUT.
  initial begin
    ser_ack = 1'b1;
    busyCnt = 0;
    forever begin
      @(posedge clk);
      #2;
      case (ackMode)
        ACK_HIGH: ser_ack = 1'b1;
        ACK_LOW: begin
          ser_ack = 1'b0;
          busyCnt = 0;
        end
        default: begin
          if (ser_req && ser_ack) begin
            ser_ack = 1'b0;
            busyCnt = busyLen;
          end else if (!ser_ack) begin
            if (busyCnt > 0) busyCnt--;
            else ser_ack = 1'b1;
          end
        end
      endcase
    end
  end

  initial begin
    logic prevReq;
    frame_t expFrame;
    prevReq = 1'b0;
    forever begin
      @(negedge clk);
      if (ser_req && !prevReq) begin
        if (expQ.size() == 0) begin
          checks++;
          errors++;
          $display("[TB] FAIL unexpectedFrame actual=%0h expected=none",
                   {ser_data, ser_crc, ser_flags, ser_data_err, ser_crc_err, ser_op_err});
        end else begin
          expFrame = expQ.pop_front();
          checkOutput("frame", {ser_data, ser_crc, ser_flags, ser_data_err, ser_crc_err, ser_op_err},
                      expFrame);
        end
      end
      prevReq = ser_req;
    end
  end

  initial begin
    #1000000;
    $display("[TB] FAIL watchdog actual=running expected=finished");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    int n;
    int hi;
    rst       = 1'b1;
    res_valid = 1'b0;
    res_data  = 32'h0;
    res_crc   = 3'b000;
    res_flags = 4'b0000;
    err_valid = 1'b0;
    err_bits  = 3'b000;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    checkOutput("rstReq", 42'(ser_req), 42'(0));
    checkOutput("rstLevel", 42'(fifo_level), 42'(0));
    checkOutput("rstReady", 42'({res_ready, err_ready, tx_timeout}), 42'(3'b110));
    checkOutput("rstPayload", {ser_data, ser_crc, ser_flags, ser_data_err, ser_crc_err, ser_op_err}, 42'(0));

    $display("[TB] single result");
    busyLen = 20;
    applyStimulus(32'h12345678, 3'b101, 4'b0010, 1'b1);
    n = 0;
    while (!ser_req && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (n >= 50) waitExpired("singleReq");
    hi = 0;
    while (ser_req && hi < 2000) begin
      hi++;
      @(negedge clk);
    end
    checkOutput("reqHighCycles", 42'(hi), 42'(2));
    checkOutput("payloadHeld", 42'(ser_data), 42'(32'h12345678));
    waitDrain(200);
    checkOutput("levelEmpty", 42'(fifo_level), 42'(0));

    $display("[TB] fifo full");
    ackMode = ACK_LOW;
    repeat (2) @(negedge clk);
    applyStimulus(32'hA0000001, 3'b001, 4'b0001, 1'b1);
    applyStimulus(32'hA0000002, 3'b010, 4'b0010, 1'b1);
    applyStimulus(32'hA0000003, 3'b011, 4'b0100, 1'b1);
    applyStimulus(32'hA0000004, 3'b100, 4'b1000, 1'b1);
    checkOutput("fullLevel", 42'({fifo_level, res_ready}), 42'({5'd4, 1'b0}));
    res_valid = 1'b1;
    res_data  = 32'hA0000005;
    res_crc   = 3'b111;
    res_flags = 4'b1111;
    repeat (3) @(negedge clk);
    checkOutput("fullHold", 42'({fifo_level, res_ready}), 42'({5'd4, 1'b0}));
    ackMode = ACK_AUTO;
    busyLen = 6;
    n = 0;
    while (!res_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (n >= 50) waitExpired("fullPop");
    checkOutput("levelAfterPop", 42'(fifo_level), 42'(3));
    expQ.push_back(resFrame(32'hA0000005, 3'b111, 4'b1111));
    @(negedge clk);
    res_valid = 1'b0;
    checkOutput("levelRefill", 42'(fifo_level), 42'(4));
    waitDrain(500);

    $display("[TB] push and pop at level one");
    busyLen = 5;
    applyStimulus(32'hB0000001, 3'b110, 4'b0011, 1'b1);
    @(negedge clk);
    applyStimulus(32'hB0000002, 3'b011, 4'b1100, 1'b1);
    checkOutput("pushPopLevel1", 42'(fifo_level), 42'(1));
    waitDrain(300);

    $display("[TB] error priority");
    busyLen = 10;
    applyStimulus(32'hC0000001, 3'b001, 4'b0101, 1'b1);
    applyStimulus(32'hC0000002, 3'b010, 4'b1010, 1'b0);
    repeat (3) @(negedge clk);
    checkOutput("inWaitDone", 42'({ser_req, ser_ack, fifo_level}), 42'({1'b0, 1'b0, 5'd1}));
    applyErrorStimulus(3'b010, 1'b1);
    expQ.push_back(resFrame(32'hC0000002, 3'b010, 4'b1010));
    checkOutput("errReadyLow", 42'(err_ready), 42'(0));
    waitDrain(300);

    $display("[TB] error bits zero");
    applyErrorStimulus(3'b000, 1'b0);
    repeat (5) @(negedge clk);
    checkOutput("zeroErrIgnored", 42'({ser_req, err_ready}), 42'(2'b01));
    applyErrorStimulus(3'b101, 1'b1);
    waitDrain(200);

    $display("[TB] ack timeout");
    ackMode = ACK_HIGH;
    repeat (2) @(negedge clk);
    applyStimulus(32'hD0000001, 3'b100, 4'b0110, 1'b1);
    applyStimulus(32'hD0000002, 3'b001, 4'b1001, 1'b1);
    hi = 0;
    while (ser_req && hi < 1100) begin
      hi++;
      @(negedge clk);
    end
    checkOutput("timeoutReqCycles", 42'(hi), 42'(1025));
    checkOutput("txTimeoutSet", 42'({tx_timeout, fifo_level}), 42'({1'b1, 5'd1}));
    ackMode = ACK_AUTO;
    busyLen = 5;
    waitDrain(200);
    checkOutput("txTimeoutSticky", 42'(tx_timeout), 42'(1));

    $display("[TB] reset mid frame");
    busyLen = 30;
    applyStimulus(32'hE0000001, 3'b101, 4'b0111, 1'b1);
    applyStimulus(32'hE0000002, 3'b110, 4'b1110, 1'b0);
    applyStimulus(32'hE0000003, 3'b111, 4'b1101, 1'b0);
    applyStimulus(32'hE0000004, 3'b011, 4'b1011, 1'b0);
    checkOutput("levelBeforeReset", 42'({ser_req, fifo_level}), 42'({1'b0, 5'd3}));
    rst = 1'b1;
    @(negedge clk);
    checkOutput("midRstReqLevel", 42'({ser_req, fifo_level}), 42'(0));
    checkOutput("midRstPayload", {ser_data, ser_crc, ser_flags, ser_data_err, ser_crc_err, ser_op_err}, 42'(0));
    checkOutput("midRstFlags", 42'({res_ready, err_ready, tx_timeout}), 42'(3'b110));
    rst = 1'b0;
    waitDrain(200);

    checkOutput("scoreboardEmpty", 42'(expQ.size()), 42'(0));
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
